// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU instruction side.
// Contents:
//   alu_op_t       ALU opcodes shared with the ALU; OP_LOAD never reaches the ALU.
//   *_MSB/*_LSB    bit positions of the instruction byte fields.
//   issue_state_t  state encoding of the issue sequencer.
//   instr_* / imm_value  helpers that extract instruction fields.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_LOAD = 3'b111
  } alu_op_t;

  localparam int OP_MSB      = 7;
  localparam int OP_LSB      = 5;
  localparam int RD_MSB      = 4;
  localparam int RD_LSB      = 3;
  localparam int RS_MSB      = 2;
  localparam int RS_LSB      = 1;
  localparam int IMM_BIT     = 0;
  localparam int IMM_VAL_MSB = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_IMM,
    ST_ISSUE,
    ST_WAIT,
    ST_WB
  } issue_state_t;

  function automatic logic [2:0] instr_op(input logic [7:0] b);
    return b[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [1:0] instr_rd(input logic [7:0] b);
    return b[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [1:0] instr_rs(input logic [7:0] b);
    return b[RS_MSB:RS_LSB];
  endfunction

  function automatic logic instr_imm(input logic [7:0] b);
    return b[IMM_BIT];
  endfunction

  // Upper nibble of an immediate byte is ignored.
  function automatic logic [3:0] imm_value(input logic [7:0] b);
    return b[IMM_VAL_MSB:0];
  endfunction

endpackage

// File: rtl/regfile_4x4.sv
// Architectural register file: NREG entries of 4 bits.
// Ports:
//   clk, rst          clock and synchronous active-high clear of all entries
//   ra_addr/ra_data   asynchronous read port A
//   rb_addr/rb_data   asynchronous read port B
//   we, wa, wd        synchronous write port
module regfile_4x4 #(
  parameter int NREG = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ra_addr,
  output logic [3:0] ra_data,
  input  logic [1:0] rb_addr,
  output logic [3:0] rb_data,
  input  logic       we,
  input  logic [1:0] wa,
  input  logic [3:0] wd
);

  logic [3:0] regs [NREG];

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer: accepts two-address instruction bytes over valid/ready,
// reads operands from the register file, drives the external ALU, waits its
// latency and writes the result back.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   instr_valid/instr_data/instr_ready  instruction byte stream
//   alu_en/alu_opcode/alu_in_1/alu_in_2 ALU issue interface (operands held through WB)
//   alu_out                         ALU result, valid ALU_LAT cycles after alu_en
//   result_valid/result_data/result_rd  write-back notification
//   busy                            high outside IDLE
//
// state      | meaning
// IDLE       | ready for an instruction byte
// FETCH_IMM  | instruction latched, waiting for its immediate byte
// ISSUE      | alu_en pulse, operands already registered
// WAIT       | remaining ALU latency counting down
// WB         | result published and written to the register file
module alu_issue_ctrl
  import cpu_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int NREG    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [7:0] instr_data,
  output logic       instr_ready,
  output logic       alu_en,
  output logic [2:0] alu_opcode,
  output logic [3:0] alu_in_1,
  output logic [3:0] alu_in_2,
  input  logic [3:0] alu_out,
  output logic       result_valid,
  output logic [3:0] result_data,
  output logic [1:0] result_rd,
  output logic       busy
);

  // ISSUE counts as the first latency cycle, so WAIT covers ALU_LAT-1 cycles.
  localparam logic [1:0] WAIT_LOAD = 2'(ALU_LAT > 1 ? ALU_LAT - 2 : 0);

  issue_state_t state_q, state_d;
  logic [2:0]   op_q;
  logic [1:0]   rd_q;
  logic [3:0]   src_q;
  logic [1:0]   wait_cnt_q;
  logic         xfer;
  logic [1:0]   ra_addr;
  logic [3:0]   ra_data;
  logic [3:0]   rb_data;

  // Strobes are forced low in the reset cycle regardless of the old state.
  assign instr_ready  = !rst && (state_q == ST_IDLE || state_q == ST_FETCH_IMM);
  assign xfer         = instr_valid && instr_ready;
  assign alu_en       = !rst && (state_q == ST_ISSUE);
  assign result_valid = !rst && (state_q == ST_WB);
  assign result_rd    = result_valid ? rd_q : '0;
  assign result_data  = !result_valid ? '0 : ((op_q == OP_LOAD) ? src_q : alu_out);
  assign busy         = (state_q != ST_IDLE);

  // In IDLE the destination comes straight off the incoming byte; after that
  // the latched copy is used (immediate-form operand read).
  assign ra_addr = (state_q == ST_IDLE) ? instr_rd(instr_data) : rd_q;

  regfile_4x4 #(.NREG(NREG)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (ra_addr),
    .ra_data (ra_data),
    .rb_addr (instr_rs(instr_data)),
    .rb_data (rb_data),
    .we      (result_valid),
    .wa      (rd_q),
    .wd      (result_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if (instr_imm(instr_data))                state_d = ST_FETCH_IMM;
          else if (instr_op(instr_data) == OP_LOAD) state_d = ST_WB;
          else                                      state_d = ST_ISSUE;
        end
      end
      ST_FETCH_IMM: begin
        if (xfer) state_d = (op_q == OP_LOAD) ? ST_WB : ST_ISSUE;
      end
      ST_ISSUE: state_d = (ALU_LAT == 1) ? ST_WB : ST_WAIT;
      ST_WAIT:  if (wait_cnt_q == '0) state_d = ST_WB;
      ST_WB:    state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      src_q      <= '0;
      wait_cnt_q <= '0;
      alu_opcode <= '0;
      alu_in_1   <= '0;
      alu_in_2   <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == ST_IDLE && xfer) begin
        op_q <= instr_op(instr_data);
        rd_q <= instr_rd(instr_data);
        if (!instr_imm(instr_data)) src_q <= rb_data;
      end
      if (state_q == ST_FETCH_IMM && xfer) begin
        src_q <= imm_value(instr_data);
      end

      // Operands sampled at the ISSUE-entry edge; a same-cycle rd==rs read
      // sees the pre-write value since no write can be in flight here.
      if (state_d == ST_ISSUE) begin
        alu_opcode <= (state_q == ST_IDLE) ? instr_op(instr_data) : op_q;
        alu_in_1   <= ra_data;
        alu_in_2   <= (state_q == ST_IDLE) ? rb_data : imm_value(instr_data);
      end

      if (state_q == ST_ISSUE) begin
        wait_cnt_q <= WAIT_LOAD;
      end else if (state_q == ST_WAIT && wait_cnt_q != '0) begin
        wait_cnt_q <= wait_cnt_q - 2'd1;
      end
    end
  end

endmodule
